// File: rtl/uart_xcvr.sv
// rtl/uart_xcvr.sv - UART transceiver with TX/RX FIFOs
// Define UART_PARITY_EN to add an even-parity bit after D7 on both directions.
module uart_xcvr #(
  parameter int CLK_DIV     = 434,
  parameter int FDEPTH_LOG2 = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  output logic                   tx,
  input  logic                   rx_rden,
  output logic [7:0]             rx_rdata,
  output logic                   rx_fifo_dvalid,
  output logic                   rx_fifo_full,
  output logic                   rx_fifo_overrun,
  output logic                   rx_fifo_underrun,
  output logic [FDEPTH_LOG2:0]   rx_fifo_rcntr,
  output logic                   rx_frame_err,
  input  logic [7:0]             tx_wdata,
  input  logic                   tx_wten,
  output logic                   tx_fifo_full,
  output logic                   tx_fifo_overrun,
  output logic                   tx_fifo_underrun
);
  localparam int PW = FDEPTH_LOG2;
  localparam int CW = FDEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FDEPTH_LOG2;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [15:0]   BIT_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0]   HALF_LAST = 16'(CLK_DIV / 2 - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // TX FIFO
  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] tx_wptr, tx_rptr;
  logic [CW-1:0] tx_cnt, tx_cnt_nxt;
  logic          tx_dvalid, tx_pop, tx_push_ok, tx_pop_ok;
  logic [7:0]    tx_head;

  assign tx_push_ok = tx_wten && !tx_fifo_full;
  assign tx_pop_ok  = tx_pop && tx_dvalid;
  assign tx_cnt_nxt = tx_cnt + CW'(tx_push_ok) - CW'(tx_pop_ok);
  assign tx_head    = tx_mem[tx_rptr];

  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wptr] <= tx_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wptr <= '0; tx_rptr <= '0; tx_cnt <= '0;
      tx_fifo_full <= 1'b0; tx_dvalid <= 1'b0;
      tx_fifo_overrun <= 1'b0; tx_fifo_underrun <= 1'b0;
    end else begin
      if (tx_push_ok) tx_wptr <= tx_wptr + PW'(1);
      if (tx_pop_ok)  tx_rptr <= tx_rptr + PW'(1);
      tx_cnt       <= tx_cnt_nxt;
      tx_fifo_full <= (tx_cnt_nxt == FULL_CNT);
      tx_dvalid    <= (tx_cnt_nxt != '0);
      if (tx_wten && tx_fifo_full) tx_fifo_overrun  <= 1'b1;
      if (tx_pop && !tx_dvalid)    tx_fifo_underrun <= 1'b1;
    end
  end

  // TX FSM; tx is registered from the next state so each level lasts exactly CLK_DIV clocks
  state_t      tx_state, tx_state_nxt;
  logic [15:0] tx_clk, tx_clk_nxt;
  logic [2:0]  tx_bit, tx_bit_nxt;
  logic [7:0]  tx_shift, tx_shift_nxt;
  logic        tx_nxt, tx_bit_end, tx_load;
`ifdef UART_PARITY_EN
  logic        tx_par, tx_par_nxt;
`endif

  assign tx_bit_end = (tx_clk == BIT_LAST);

  always_comb begin
    tx_state_nxt = tx_state;
    tx_clk_nxt   = tx_bit_end ? 16'd0 : tx_clk + 16'd1;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_pop       = 1'b0;
    tx_load      = 1'b0;
    tx_nxt       = 1'b1;
`ifdef UART_PARITY_EN
    tx_par_nxt   = tx_par;
`endif
    case (tx_state)
      S_IDLE: begin
        tx_clk_nxt = 16'd0;
        tx_load    = tx_dvalid;
      end
      S_START: if (tx_bit_end) begin
        tx_state_nxt = S_DATA;
        tx_bit_nxt   = 3'd0;
      end
      S_DATA: if (tx_bit_end) begin
        tx_shift_nxt = tx_shift >> 1;
        tx_bit_nxt   = tx_bit + 3'd1;
`ifdef UART_PARITY_EN
        if (tx_bit == 3'd7) tx_state_nxt = S_PARITY;
`else
        if (tx_bit == 3'd7) tx_state_nxt = S_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (tx_bit_end) tx_state_nxt = S_STOP;
`endif
      S_STOP: if (tx_bit_end) begin
        // chain straight into the next start bit so back-to-back frames have no idle gap
        tx_state_nxt = S_IDLE;
        tx_load      = tx_dvalid;
      end
      default: tx_state_nxt = S_IDLE;
    endcase
    if (tx_load) begin
      tx_pop       = 1'b1;
      tx_state_nxt = S_START;
      tx_shift_nxt = tx_head;
`ifdef UART_PARITY_EN
      tx_par_nxt   = ^tx_head;
`endif
    end
    case (tx_state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = tx_shift_nxt[0];
`ifdef UART_PARITY_EN
      S_PARITY: tx_nxt = tx_par_nxt;
`endif
      default:  tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= S_IDLE; tx_clk <= '0; tx_bit <= '0; tx_shift <= '0; tx <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_nxt; tx_clk <= tx_clk_nxt; tx_bit <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt; tx <= tx_nxt;
`ifdef UART_PARITY_EN
      tx_par <= tx_par_nxt;
`endif
    end
  end

  // RX synchroniser and FSM
  logic [1:0]  rx_sync;
  logic        rx_s, rx_prev, rx_push, rx_err, rx_par_ok;
  state_t      rx_state, rx_state_nxt;
  logic [15:0] rx_clk, rx_clk_nxt;
  logic [2:0]  rx_bit, rx_bit_nxt;
  logic [7:0]  rx_shift, rx_shift_nxt;
`ifdef UART_PARITY_EN
  logic        rx_par, rx_par_nxt;
  assign rx_par_ok = ~(^rx_shift ^ rx_par);
`else
  assign rx_par_ok = 1'b1;
`endif

  assign rx_s = rx_sync[1];

  always_comb begin
    rx_state_nxt = rx_state;
    rx_clk_nxt   = rx_clk + 16'd1;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_push      = 1'b0;
    rx_err       = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_nxt   = rx_par;
`endif
    case (rx_state)
      S_IDLE: begin
        rx_clk_nxt = 16'd0;
        if (rx_prev && !rx_s) rx_state_nxt = S_START;
      end
      S_START: if (rx_clk == HALF_LAST) begin
        rx_clk_nxt   = 16'd0;
        rx_bit_nxt   = 3'd0;
        rx_state_nxt = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_clk == BIT_LAST) begin
        rx_clk_nxt   = 16'd0;
        rx_shift_nxt = {rx_s, rx_shift[7:1]};
        rx_bit_nxt   = rx_bit + 3'd1;
`ifdef UART_PARITY_EN
        if (rx_bit == 3'd7) rx_state_nxt = S_PARITY;
`else
        if (rx_bit == 3'd7) rx_state_nxt = S_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (rx_clk == BIT_LAST) begin
        rx_clk_nxt   = 16'd0;
        rx_par_nxt   = rx_s;
        rx_state_nxt = S_STOP;
      end
`endif
      S_STOP: if (rx_clk == BIT_LAST) begin
        rx_state_nxt = S_IDLE;
        rx_push      = rx_s && rx_par_ok;
        rx_err       = !(rx_s && rx_par_ok);
      end
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_sync <= 2'b11; rx_prev <= 1'b1;
      rx_state <= S_IDLE; rx_clk <= '0; rx_bit <= '0; rx_shift <= '0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par <= 1'b0;
`endif
    end else begin
      rx_sync <= {rx_sync[0], rx}; rx_prev <= rx_s;
      rx_state <= rx_state_nxt; rx_clk <= rx_clk_nxt; rx_bit <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
      if (rx_err) rx_frame_err <= 1'b1;
`ifdef UART_PARITY_EN
      rx_par <= rx_par_nxt;
`endif
    end
  end

  // RX FIFO, first-word-fall-through head
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] rx_wptr, rx_rptr;
  logic [CW-1:0] rx_cnt_nxt;
  logic          rx_push_ok, rx_pop_ok;

  assign rx_push_ok = rx_push && !rx_fifo_full;
  assign rx_pop_ok  = rx_rden && rx_fifo_dvalid;
  assign rx_cnt_nxt = rx_fifo_rcntr + CW'(rx_push_ok) - CW'(rx_pop_ok);
  assign rx_rdata   = rx_mem[rx_rptr];

  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem[rx_wptr] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_wptr <= '0; rx_rptr <= '0; rx_fifo_rcntr <= '0;
      rx_fifo_full <= 1'b0; rx_fifo_dvalid <= 1'b0;
      rx_fifo_overrun <= 1'b0; rx_fifo_underrun <= 1'b0;
    end else begin
      if (rx_push_ok) rx_wptr <= rx_wptr + PW'(1);
      if (rx_pop_ok)  rx_rptr <= rx_rptr + PW'(1);
      rx_fifo_rcntr  <= rx_cnt_nxt;
      rx_fifo_full   <= (rx_cnt_nxt == FULL_CNT);
      rx_fifo_dvalid <= (rx_cnt_nxt != '0);
      if (rx_push && rx_fifo_full)    rx_fifo_overrun  <= 1'b1;
      if (rx_rden && !rx_fifo_dvalid) rx_fifo_underrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_xcvr.sv
// tb/tb_uart_xcvr.sv - scoreboard testbench for uart_xcvr at CLK_DIV=4, FDEPTH_LOG2=2
module tb_uart_xcvr;
  localparam int CLK_DIV = 4;
  localparam int FDL = 2;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_drv = 1'b1;
  logic loop_en = 1'b0;
  logic rx_line;
  logic tx;
  logic rx_rden = 1'b0;
  logic [7:0] rx_rdata;
  logic rx_fifo_dvalid, rx_fifo_full, rx_fifo_overrun, rx_fifo_underrun, rx_frame_err;
  logic [FDL:0] rx_fifo_rcntr;
  logic [7:0] tx_wdata = 8'h00;
  logic tx_wten = 1'b0;
  logic tx_fifo_full, tx_fifo_overrun, tx_fifo_underrun;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_exp[$];
  logic       tx_exp[$];

  assign rx_line = loop_en ? tx : rx_drv;

  uart_xcvr #(.CLK_DIV(CLK_DIV), .FDEPTH_LOG2(FDL)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx_line), .tx(tx),
    .rx_rden(rx_rden), .rx_rdata(rx_rdata), .rx_fifo_dvalid(rx_fifo_dvalid),
    .rx_fifo_full(rx_fifo_full), .rx_fifo_overrun(rx_fifo_overrun),
    .rx_fifo_underrun(rx_fifo_underrun), .rx_fifo_rcntr(rx_fifo_rcntr),
    .rx_frame_err(rx_frame_err), .tx_wdata(tx_wdata), .tx_wten(tx_wten),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_overrun(tx_fifo_overrun),
    .tx_fifo_underrun(tx_fifo_underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic stop_bit);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
`ifdef UART_PARITY_EN
    f[9] = ^d;
    f[10] = stop_bit;
`else
    f[9] = stop_bit;
`endif
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [10:0] f);
    for (int i = 0; i < NBITS; i++) begin
      rx_drv = f[i];
      tick(CLK_DIV);
    end
    rx_drv = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic drain_rx(input string tag);
    logic [7:0] exp;
    while (rx_exp.size() > 0) begin
      exp = rx_exp.pop_front();
      checks++;
      if (rx_fifo_dvalid !== 1'b1) begin
        errors++;
        $display("FAIL %s_missing: dvalid=%b required 1 for byte %h", tag, rx_fifo_dvalid, exp);
      end else begin
        checks++;
        if (rx_rdata !== exp) begin
          errors++;
          $display("FAIL %s_data: rx_rdata=%h required %h", tag, rx_rdata, exp);
        end
        rx_rden = 1'b1;
        tick(1);
        rx_rden = 1'b0;
      end
    end
    checks++;
    if (rx_fifo_dvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s_extra: dvalid=%b required 0 (rdata=%h)", tag, rx_fifo_dvalid, rx_rdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({tx, rx_fifo_dvalid, rx_fifo_full, rx_fifo_overrun, rx_fifo_underrun, rx_frame_err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_rx_flags: tx,dv,full,ovr,unr,ferr=%b required 100000",
               {tx, rx_fifo_dvalid, rx_fifo_full, rx_fifo_overrun, rx_fifo_underrun, rx_frame_err});
    end
    checks++;
    if ({tx_fifo_full, tx_fifo_overrun, tx_fifo_underrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_tx_flags: full,ovr,unr=%b required 000",
               {tx_fifo_full, tx_fifo_overrun, tx_fifo_underrun});
    end
    checks++;
    if (rx_fifo_rcntr !== 3'd0) begin
      errors++;
      $display("FAIL reset_rcntr: rcntr=%0d required 0", rx_fifo_rcntr);
    end
    rst_n = 1'b1;
    tick(2);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_tx: tx=%b required 1", tx);
    end
  endtask

  task automatic test_tx_waveform();
    logic [10:0] f;
    logic e;
    int lat;
    f = frame_bits(8'hA5, 1'b1);
    for (int i = 0; i < NBITS; i++) tx_exp.push_back(f[i]);
    tx_wdata = 8'hA5;
    tx_wten = 1'b1;
    tick(1);
    tx_wten = 1'b0;
    lat = 1;
    while (tx !== 1'b0 && lat < 2) begin
      tick(1);
      lat++;
    end
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL tx_start_latency: tx=%b required 0 within 2 clocks", tx);
    end else begin
      for (int b = 0; b < NBITS; b++) begin
        e = tx_exp.pop_front();
        for (int c = 0; c < CLK_DIV; c++) begin
          checks++;
          if (tx !== e) begin
            errors++;
            $display("FAIL tx_bit%0d_clk%0d: tx=%b required %b", b, c, tx, e);
          end
          tick(1);
        end
      end
    end
    tx_exp.delete();
    tick(3);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL tx_idle_after: tx=%b required 1", tx);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [3];
    int n;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h3C;
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_wdata = bytes[i];
      tx_wten = 1'b1;
      rx_exp.push_back(bytes[i]);
      tick(1);
    end
    tx_wten = 1'b0;
    n = 0;
    while (rx_fifo_rcntr !== 3'd3 && n < 600) begin
      tick(1);
      n++;
    end
    checks++;
    if (rx_fifo_rcntr !== 3'd3) begin
      errors++;
      $display("FAIL loop_rcntr: rcntr=%0d required 3", rx_fifo_rcntr);
    end
    tick(CLK_DIV * 2);
    drain_rx("loop");
    checks++;
    if ({rx_frame_err, rx_fifo_overrun} !== 2'b00) begin
      errors++;
      $display("FAIL loop_flags: ferr,ovr=%b required 00", {rx_frame_err, rx_fifo_overrun});
    end
    loop_en = 1'b0;
  endtask

  task automatic test_rx_overrun();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) rx_exp.push_back(8'(8'h11 * (i + 1)));
      send_frame(frame_bits(8'(8'h11 * (i + 1)), 1'b1));
    end
    tick(8);
    checks++;
    if (rx_fifo_rcntr !== 3'd4) begin
      errors++;
      $display("FAIL ovr_rcntr: rcntr=%0d required 4", rx_fifo_rcntr);
    end
    checks++;
    if ({rx_fifo_full, rx_fifo_overrun, rx_frame_err} !== 3'b110) begin
      errors++;
      $display("FAIL ovr_flags: full,ovr,ferr=%b required 110", {rx_fifo_full, rx_fifo_overrun, rx_frame_err});
    end
    drain_rx("ovr");
    checks++;
    if (rx_fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL ovr_full_after_drain: full=%b required 0", rx_fifo_full);
    end
  endtask

  task automatic test_false_start();
    rx_drv = 1'b0;
    tick(1);
    rx_drv = 1'b1;
    tick(20);
    checks++;
    if ({rx_fifo_dvalid, rx_frame_err} !== 2'b00 || rx_fifo_rcntr !== 3'd0) begin
      errors++;
      $display("FAIL false_start: dv,ferr=%b rcntr=%0d required 00 and 0",
               {rx_fifo_dvalid, rx_frame_err}, rx_fifo_rcntr);
    end
    rx_exp.push_back(8'h5A);
    send_frame(frame_bits(8'h5A, 1'b1));
    tick(8);
    drain_rx("after_false_start");
  endtask

  task automatic test_frame_err();
    send_frame(frame_bits(8'h55, 1'b0));
    tick(8);
    checks++;
    if (rx_frame_err !== 1'b1 || rx_fifo_rcntr !== 3'd0) begin
      errors++;
      $display("FAIL stop_err: ferr=%b rcntr=%0d required 1 and 0", rx_frame_err, rx_fifo_rcntr);
    end
`ifdef UART_PARITY_EN
    begin
      logic [10:0] f;
      apply_reset();
      f = frame_bits(8'h01, 1'b1);
      f[9] = 1'b0;
      send_frame(f);
      tick(8);
      checks++;
      if (rx_frame_err !== 1'b1 || rx_fifo_rcntr !== 3'd0) begin
        errors++;
        $display("FAIL parity_err: ferr=%b rcntr=%0d required 1 and 0", rx_frame_err, rx_fifo_rcntr);
      end
    end
`endif
  endtask

  task automatic test_reset_midframe();
    int fall_at;
    apply_reset();
    rx_rden = 1'b1;
    tick(1);
    rx_rden = 1'b0;
    checks++;
    if (rx_fifo_underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_pre: underrun=%b required 1", rx_fifo_underrun);
    end
    fall_at = -1;
    tx_wten = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tx_wdata = 8'(8'h0F + k);
      tick(1);
      if (tx === 1'b0 && fall_at < 0) fall_at = k;
      if (k == 5) begin
        checks++;
        if ({tx_fifo_full, tx_fifo_overrun} !== 2'b10) begin
          errors++;
          $display("FAIL txfifo_5push: full,ovr=%b required 10", {tx_fifo_full, tx_fifo_overrun});
        end
      end
    end
    tx_wten = 1'b0;
    checks++;
    if ({tx_fifo_full, tx_fifo_overrun} !== 2'b11) begin
      errors++;
      $display("FAIL txfifo_6push: full,ovr=%b required 11", {tx_fifo_full, tx_fifo_overrun});
    end
    checks++;
    if (fall_at < 1 || fall_at > 2) begin
      errors++;
      $display("FAIL midframe_start: tx fell at clock %0d required 1..2", fall_at);
    end else begin
      tick(fall_at + 17 - 6);
      checks++;
      if (tx !== 1'b0) begin
        errors++;
        $display("FAIL midframe_bit4: tx=%b required 0", tx);
      end
      rst_n = 1'b0;
      tick(1);
      checks++;
      if (tx !== 1'b1) begin
        errors++;
        $display("FAIL midframe_tx: tx=%b required 1", tx);
      end
      checks++;
      if ({rx_fifo_dvalid, rx_fifo_full, rx_fifo_overrun, rx_fifo_underrun, rx_frame_err,
           tx_fifo_full, tx_fifo_overrun, tx_fifo_underrun} !== 8'h00 || rx_fifo_rcntr !== 3'd0) begin
        errors++;
        $display("FAIL midframe_flags: flags=%b rcntr=%0d required 00000000 and 0",
                 {rx_fifo_dvalid, rx_fifo_full, rx_fifo_overrun, rx_fifo_underrun, rx_frame_err,
                  tx_fifo_full, tx_fifo_overrun, tx_fifo_underrun}, rx_fifo_rcntr);
      end
      rst_n = 1'b1;
      tick(CLK_DIV * 3);
      checks++;
      if (tx !== 1'b1) begin
        errors++;
        $display("FAIL midframe_idle: tx=%b required 1", tx);
      end
    end
    rx_rden = 1'b1;
    tick(1);
    rx_rden = 1'b0;
    checks++;
    if ({rx_fifo_underrun, rx_fifo_dvalid} !== 2'b10 || rx_fifo_rcntr !== 3'd0) begin
      errors++;
      $display("FAIL underrun_post: underrun,dv=%b rcntr=%0d required 10 and 0",
               {rx_fifo_underrun, rx_fifo_dvalid}, rx_fifo_rcntr);
    end
  endtask

  initial begin
    test_reset();
    test_tx_waveform();
    test_loopback();
    test_rx_overrun();
    test_false_start();
    test_frame_err();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_xcvr.md
UART_XCVR -- requirements
Module: uart_xcvr

Interface
REQ-001 Parameter CLK_DIV, default 434: clocks per UART bit; legal range 4..65535.
REQ-002 Parameter FDEPTH_LOG2, default 3: each FIFO holds 2**FDEPTH_LOG2 bytes; legal range 1..6.
REQ-003 Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rx  in  1  serial input, asynchronous, idle high.
- tx  out  1  serial output, idle high.
- rx_rden  in  1  pop RX FIFO head.
- rx_rdata  out  8  RX FIFO head byte, first-word-fall-through.
- rx_fifo_dvalid  out  1  RX FIFO non-empty.
- rx_fifo_full  out  1  RX FIFO full.
- rx_fifo_overrun  out  1  sticky: a received byte was dropped.
- rx_fifo_underrun  out  1  sticky: a pop was attempted while empty.
- rx_fifo_rcntr  out  FDEPTH_LOG2+1  RX FIFO occupancy.
- rx_frame_err  out  1  sticky: a stop bit (or parity, see REQ-020) failed.
- tx_wdata  in  8  byte to transmit.
- tx_wten  in  1  push tx_wdata.
- tx_fifo_full  out  1  TX FIFO full.
- tx_fifo_overrun  out  1  sticky: a push was attempted while full.
- tx_fifo_underrun  out  1  sticky: internal pop while empty; this is a design error and stays 0 in correct RTL.

Function
REQ-004 Frame format: start bit (0), 8 data bits LSB first, optional parity bit (REQ-020), 1 stop bit (1); every bit lasts exactly CLK_DIV clocks.
REQ-005 TX FSM states are IDLE, START, DATA, [PARITY], STOP; while in IDLE with the TX FIFO non-empty, it pops the head byte and enters START on the next clock.
REQ-006 The tx output falls at most 2 clocks after tx_wten is asserted to an empty TX FIFO while the FSM is in IDLE.
REQ-007 The TX FSM advances one bit per CLK_DIV clocks; STOP returns to IDLE, and back-to-back frames carry no extra idle bits.
REQ-008 The rx input passes through a 2-flop synchroniser before any use.
REQ-009 RX FSM states are IDLE, START, DATA, [PARITY], STOP.
- IDLE→START on a synchronised falling edge.
- In START, the line is sampled at CLK_DIV/2 (integer division) clocks; if high, this is a false start and the FSM returns to IDLE.
- Each later bit is sampled CLK_DIV clocks after the previous sample.
REQ-010 At the STOP sample, the FSM returns to IDLE immediately; it pushes the byte only if the stop bit is 1 and, when enabled, parity is correct; otherwise it drops the byte and sets rx_frame_err.
REQ-011 FIFOs are circular buffers with FDEPTH_LOG2-bit pointers that wrap from 2**FDEPTH_LOG2-1 to 0; a FIFO is full when its occupancy equals 2**FDEPTH_LOG2.
REQ-012 Full and empty are evaluated on the pre-edge state:
- A push to a full FIFO is dropped and sets overrun, even if a pop happens in the same cycle.
- A pop from an empty FIFO is ignored and sets underrun, even if a push happens in the same cycle; that push succeeds.
REQ-013 A simultaneous push and pop on a FIFO that is neither full nor empty leaves occupancy unchanged.
REQ-014 rx_rdata equals the head entry whenever rx_fifo_dvalid=1; its value is don't-care when the FIFO is empty.
REQ-015 rx_fifo_rcntr, rx_fifo_dvalid and all full flags are registered and update in the same clock as the pointer change.
REQ-016 Sticky flags clear only on reset.

Reset
REQ-017 When rst_n=0 at a clock edge:
- both FSMs go to IDLE;
- bit and clock counters, FIFO pointers and occupancy go to 0;
- all sticky flags, full and dvalid flags go to 0;
- tx goes to 1; the synchroniser flops go to 1.
REQ-018 Reset asserted mid-frame aborts the frame: tx is high on the first clock after the reset edge, and a partially received byte is discarded.
REQ-019 FIFO storage is not reset.

Configuration
REQ-020 Macro UART_PARITY_EN:
- When defined, an even-parity bit follows D7 on both TX and RX, and a parity mismatch on RX sets rx_frame_err and drops the byte.
- When undefined, frames are 8N1, the PARITY states do not exist, and rx_frame_err reflects stop-bit errors only.

Verification
REQ-021 CLK_DIV=4, FDEPTH_LOG2=2; push 0xA5 → tx shows 0,1,0,1,0,0,1,0,1,1, with each level held for 4 clocks.
REQ-022 tx looped back to rx; push 0x00, 0xFF, 0x3C → rx_fifo_rcntr reaches 3 and pops return 0x00, 0xFF, 0x3C in order.
REQ-023 5 frames received with no pops → rcntr=4, rx_fifo_full=1, rx_fifo_overrun=1, and the 5th byte is absent from the pops.
REQ-024 rx driven low for 1 clock, then high → no push, no rx_frame_err, FSM back in IDLE.
REQ-025 Frame 0x55 with stop bit 0 → rx_frame_err=1 and rcntr unchanged; with UART_PARITY_EN defined, a frame 0x01 with parity bit 0 → rx_frame_err=1.
REQ-026 rst_n=0 during bit 4 of a TX frame → tx=1 next clock, all flags 0; rx_rden with an empty RX FIFO → rx_fifo_underrun=1.
